pool_window_gen: RTL and testbench

Streaming window generator that feeds the pooling datapath. It accepts a raster-order pixel stream for one feature map (row-major, one pixel per handshake) and buffers R-1 lines internally. At each stride-aligned position it emits one packed R x C window on a single bus for a downstream combinational max/compare stage. It is the producer end of the packed-window interface, sitting between the convolution output stream and the pooling max stage.

---
 rtl/pool_window_gen.sv | 161 ++++++++++++++++
 tb/tb_pool_window_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_gen.sv
// pool_window_gen: streaming R x C window generator for the pooling stage.
// Pixels arrive in raster order. R-1 line buffers supply the upper rows of
// each new window column, and the bottom row comes straight from in_data.
// Each window lands in a registered packed output bus at stride-aligned
// positions. The design needs R >= 2 and C >= 2. The leftmost window column
// lives only in the output register, so the shift history holds C-1 columns.
module pool_window_gen #(
  parameter int data_width = 32,
  parameter int R          = 3,
  parameter int C          = 3,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int STRIDE     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [data_width-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [data_width*R*C-1:0]    out_window,
  output logic                         frame_done
);

  localparam int CW = (IMG_W  > 1) ? $clog2(IMG_W)  : 1;
  localparam int RW = (IMG_H  > 1) ? $clog2(IMG_H)  : 1;
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0] COL_LAST       = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_FIRST_EMIT = CW'(C - 1);
  localparam logic [RW-1:0] ROW_LAST       = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FIRST_EMIT = RW'(R - 1);
  localparam logic [PW-1:0] PHASE_LAST     = PW'(STRIDE - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] col_phase;
  logic [PW-1:0] row_phase;

  logic accept;
  logic emit;
  logic last_col;
  logic last_row;

  // line_buf[0] holds the previous row, line_buf[R-2] the oldest row.
  logic [data_width-1:0] line_buf [R-1][IMG_W];

  // Shift history: the right-hand C-1 columns of the most recent window.
  logic [data_width-1:0] hist [R][C-1];

  logic [data_width-1:0] new_col  [R];
  logic [data_width-1:0] win_next [R][C];
  logic [data_width*R*C-1:0] win_next_flat;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);

  // A window completes on a pixel that has R rows and C columns of the
  // current row behind it, and that sits on the stride grid in both
  // directions. The phase counters stand in for the modulo.
  assign emit = accept &&
                (row >= ROW_FIRST_EMIT) && (col >= COL_FIRST_EMIT) &&
                (row_phase == '0) && (col_phase == '0);

  // The new column is built from the line-buffer taps (oldest on top) and
  // the incoming pixel on the bottom. The candidate window is the history
  // plus that new column, packed with pixel (r,c) at slot r*C+c.
  for (genvar r = 0; r < R; r++) begin : g_row
    if (r == R - 1) begin : g_bottom
      assign new_col[r] = in_data;
    end else begin : g_tap
      assign new_col[r] = line_buf[R-2-r][col];
    end
    for (genvar c = 0; c < C; c++) begin : g_col
      if (c == C - 1) begin : g_newest
        assign win_next[r][c] = new_col[r];
      end else begin : g_older
        assign win_next[r][c] = hist[r][c];
      end
      assign win_next_flat[(r*C+c)*data_width +: data_width] = win_next[r][c];
    end
  end

  // Raster position and stride phase counters, which advance only on accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      col_phase <= '0;
      row_phase <= '0;
    end else if (accept) begin
      if (last_col) begin
        col       <= '0;
        col_phase <= '0;
        if (last_row) begin
          row       <= '0;
          row_phase <= '0;
        end else begin
          row <= row + 1'b1;
          if (row >= ROW_FIRST_EMIT) begin
            row_phase <= (row_phase == PHASE_LAST) ? '0 : row_phase + 1'b1;
          end
        end
      end else begin
        col <= col + 1'b1;
        if (col >= COL_FIRST_EMIT) begin
          col_phase <= (col_phase == PHASE_LAST) ? '0 : col_phase + 1'b1;
        end
      end
    end
  end

  // Line buffers push each column down one row on every accepted pixel, and
  // their contents after reset are irrelevant.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[0][col] <= in_data;
      for (int k = 1; k < R - 1; k++) begin
        line_buf[k][col] <= line_buf[k-1][col];
      end
    end
  end

  // The window history shifts left by one column for every accepted pixel.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C - 1; c++) begin
          hist[r][c] <= win_next[r][c+1];
        end
      end
    end
  end

  // The output register loads on an emitting accept and clears valid once the
  // window has been taken. A simultaneous take and new emit keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_window <= '0;
    end else if (emit) begin
      out_valid  <= 1'b1;
      out_window <= win_next_flat;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // frame_done pulses for one cycle after the frame's final pixel is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_col && last_row;
    end
  end

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen with two instances. Instance a is 4x4
// with a 2x2 window and stride 2. Instance b is 4x4 with a 3x3 window and
// stride 1. Expected windows are written out by hand.
module tb_pool_window_gen;

  localparam int DW = 32;

  typedef logic [DW*9-1:0] win_t;

  logic clk = 1'b0;
  logic rst_n;

  logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_frame_done;
  logic [DW-1:0]   a_in_data;
  logic [DW*4-1:0] a_out_window;

  logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_frame_done;
  logic [DW-1:0]   b_in_data;
  logic [DW*9-1:0] b_out_window;

  win_t qa[$];
  win_t qb[$];
  win_t exp_q[$];
  int   a_fd = 0;
  int   b_fd = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pool_window_gen #(.data_width(DW), .R(2), .C(2), .IMG_W(4), .IMG_H(4), .STRIDE(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_window(a_out_window),
    .frame_done(a_frame_done)
  );

  pool_window_gen #(.data_width(DW), .R(3), .C(3), .IMG_W(4), .IMG_H(4), .STRIDE(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_window(b_out_window),
    .frame_done(b_frame_done)
  );

  // Record every completed output transfer and every frame_done pulse, away from the clock edge.
  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) qa.push_back(win_t'(a_out_window));
    if (b_out_valid && b_out_ready) qb.push_back(win_t'(b_out_window));
    if (a_frame_done) a_fd++;
    if (b_frame_done) b_fd++;
  end

  // Stop a hung run with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input win_t observed, input win_t expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic win_t pack4(input logic [DW-1:0] p0, p1, p2, p3);
    return win_t'({p3, p2, p1, p0});
  endfunction

  function automatic win_t pack9(input logic [DW-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8);
    return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

  // Present one pixel to the selected instance after gap idle cycles, and
  // hold it until the instance accepts it.
  task automatic applyStimulus(input int sel, input logic [DW-1:0] pix, input int gap);
    bit done;
    int tries;
    done  = 1'b0;
    tries = 0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
    if (sel == 0) begin a_in_valid = 1'b1; a_in_data = pix; end
    else          begin b_in_valid = 1'b1; b_in_data = pix; end
    while (!done && tries < 64) begin
      @(negedge clk);
      if ((sel == 0) ? a_in_ready : b_in_ready) done = 1'b1;
      @(posedge clk); #1;
      tries++;
    end
    checkOutput($sformatf("accept_px%0d", pix), win_t'(done), win_t'(1));
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  task automatic streamFrame(input int sel, input int base, input bit bubbles);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(sel, DW'(base + i), bubbles ? int'($urandom_range(0, 2)) : 0);
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic verifyRun(input string tag, input int sel, input int start, input int fd_start,
                           input int exp_fd);
    int   n;
    win_t obs;
    n = (sel == 0) ? qa.size() - start : qb.size() - start;
    checkOutput({tag, "_count"}, win_t'(n), win_t'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < n) obs = (sel == 0) ? qa[start+i] : qb[start+i];
      else       obs = '1;
      checkOutput($sformatf("%s_win%0d", tag, i), obs, exp_q[i]);
    end
    checkOutput({tag, "_frame_done"}, win_t'((sel == 0) ? a_fd - fd_start : b_fd - fd_start),
                win_t'(exp_fd));
  endtask

  task automatic loadTile(input int base);
    exp_q = {};
    exp_q.push_back(pack4(DW'(base+0),  DW'(base+1),  DW'(base+4),  DW'(base+5)));
    exp_q.push_back(pack4(DW'(base+2),  DW'(base+3),  DW'(base+6),  DW'(base+7)));
    exp_q.push_back(pack4(DW'(base+8),  DW'(base+9),  DW'(base+12), DW'(base+13)));
    exp_q.push_back(pack4(DW'(base+10), DW'(base+11), DW'(base+14), DW'(base+15)));
  endtask

  // Hold off the first window for five cycles and confirm that both the
  // window and the input stall hold.
  task automatic stallCtrl();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (a_out_valid) seen = 1'b1;
    end
    checkOutput("stall_seen_valid", win_t'(seen), win_t'(1));
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      checkOutput($sformatf("stall%0d_ctrl", k), win_t'({a_out_valid, a_in_ready}), win_t'(2'b10));
      checkOutput($sformatf("stall%0d_win", k), win_t'(a_out_window), pack4(0, 1, 4, 5));
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
  endtask

  int sa, fa, sb, fb;

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("rst_a_ctrl", win_t'({a_out_valid, a_in_ready, a_frame_done}), win_t'(3'b010));
    checkOutput("rst_a_win",  win_t'(a_out_window), '0);
    checkOutput("rst_b_ctrl", win_t'({b_out_valid, b_in_ready, b_frame_done}), win_t'(3'b010));
    checkOutput("rst_b_win",  b_out_window, '0);
    @(posedge clk); #1;

    // Basic tiling
    $display("[TB] basic tiling");
    loadTile(0);
    sa = qa.size(); fa = a_fd;
    streamFrame(0, 0, 1'b0);
    drain();
    verifyRun("tile", 0, sa, fa, 1);

    // Overlapping 3x3 windows with stride 1
    $display("[TB] overlap");
    exp_q = {};
    exp_q.push_back(pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
    exp_q.push_back(pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    exp_q.push_back(pack9(4, 5, 6, 8, 9, 10, 12, 13, 14));
    exp_q.push_back(pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
    sb = qb.size(); fb = b_fd;
    streamFrame(1, 0, 1'b0);
    drain();
    verifyRun("overlap", 1, sb, fb, 1);

    // Backpressure
    $display("[TB] backpressure");
    loadTile(0);
    sa = qa.size(); fa = a_fd;
    a_out_ready = 1'b0;
    fork
      streamFrame(0, 0, 1'b0);
      stallCtrl();
    join
    drain();
    verifyRun("stall", 0, sa, fa, 1);

    // Random input bubbles
    $display("[TB] bubbles");
    loadTile(0);
    sa = qa.size(); fa = a_fd;
    streamFrame(0, 0, 1'b1);
    drain();
    verifyRun("bubble", 0, sa, fa, 1);

    // Reset mid-frame while window (2,3,6,7) is still pending
    $display("[TB] reset mid-frame");
    for (int i = 0; i < 7; i++) applyStimulus(0, DW'(i), 0);
    a_out_ready = 1'b0;
    applyStimulus(0, DW'(7), 0);
    @(negedge clk);
    checkOutput("pend_valid", win_t'(a_out_valid), win_t'(1));
    checkOutput("pend_win", win_t'(a_out_window), pack4(2, 3, 6, 7));
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", win_t'(a_out_valid), win_t'(0));
    checkOutput("midrst_win", win_t'(a_out_window), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    loadTile(0);
    sa = qa.size(); fa = a_fd;
    streamFrame(0, 0, 1'b0);
    drain();
    verifyRun("replay", 0, sa, fa, 1);

    // Back-to-back frames
    $display("[TB] back-to-back frames");
    loadTile(100);
    begin
      win_t second[$];
      second = exp_q;
      loadTile(0);
      exp_q = {exp_q, second};
    end
    sa = qa.size(); fa = a_fd;
    streamFrame(0, 0, 1'b0);
    streamFrame(0, 100, 1'b0);
    drain();
    verifyRun("b2b", 0, sa, fa, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
